// File: rtl/matrix_code_pkg.sv
// Shared definitions for the [8,4,4] nibble SEC-DED code: generator rows,
// syndrome columns, the parity helper and the decode status/FSM types.
package matrix_code_pkg;

    localparam logic [7:0] G0 = 8'hE1;
    localparam logic [7:0] G1 = 8'hD2;
    localparam logic [7:0] G2 = 8'hB4;
    localparam logic [7:0] G3 = 8'h78;

    // Syndrome produced by a flip of data bit 0..3 (upper nibble of each G row)
    localparam logic [3:0] SYN_D0 = 4'hE;
    localparam logic [3:0] SYN_D1 = 4'hD;
    localparam logic [3:0] SYN_D2 = 4'hB;
    localparam logic [3:0] SYN_D3 = 4'h7;

    typedef enum logic [1:0] {
        ST_OK     = 2'd0,
        ST_CORR   = 2'd1,
        ST_UNCORR = 2'd2
    } dec_status_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_DONE   = 2'd2
    } dec_state_e;

    function automatic logic [3:0] parity4(input logic [3:0] d);
        return {d[0] ^ d[1] ^ d[2],
                d[0] ^ d[1] ^ d[3],
                d[0] ^ d[2] ^ d[3],
                d[1] ^ d[2] ^ d[3]};
    endfunction

endpackage

// File: rtl/matrix_decode_secded_if.sv
// Request/result bundle between a client and the SEC-DED word decoder.
interface matrix_decode_secded_if;
    logic         start;
    logic [127:0] Encoded_MEM_in;
    logic         busy;
    logic         valid_out;
    logic [63:0]  data_out;
    logic [4:0]   corr_count;
    logic [15:0]  uncorr_mask;
    logic         err_uncorr;

    modport master (
        output start, Encoded_MEM_in,
        input  busy, valid_out, data_out, corr_count, uncorr_mask, err_uncorr
    );

    modport slave (
        input  start, Encoded_MEM_in,
        output busy, valid_out, data_out, corr_count, uncorr_mask, err_uncorr
    );
endinterface

// File: rtl/secded_cw_dec.sv
// Combinational decode of one 8-bit codeword into its corrected data nibble
// and a status of OK / corrected / uncorrectable.
module secded_cw_dec
    import matrix_code_pkg::*;
(
    input  logic [7:0]  cw_i,
    output logic [3:0]  data_o,
    output dec_status_e status_o
);

    logic [3:0] syn;

    assign syn = cw_i[7:4] ^ parity4(cw_i[3:0]);

    always_comb begin
        data_o   = cw_i[3:0];
        status_o = ST_OK;
        case (syn)
            4'h0: status_o = ST_OK;
            // A lone syndrome bit means the check bit itself flipped
            4'h1, 4'h2, 4'h4, 4'h8: status_o = ST_CORR;
            SYN_D0: begin data_o[0] = ~cw_i[0]; status_o = ST_CORR; end
            SYN_D1: begin data_o[1] = ~cw_i[1]; status_o = ST_CORR; end
            SYN_D2: begin data_o[2] = ~cw_i[2]; status_o = ST_CORR; end
            SYN_D3: begin data_o[3] = ~cw_i[3]; status_o = ST_CORR; end
            default: status_o = ST_UNCORR;
        endcase
    end

endmodule

// File: rtl/matrix_decode_secded.sv
// Decodes 16 SEC-DED codewords into a 64-bit word, LANES codewords per cycle,
// and publishes data plus correction/uncorrectable status with a valid pulse.
module matrix_decode_secded
    import matrix_code_pkg::*;
#(
    parameter int K     = 4,
    parameter int LANES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    matrix_decode_secded_if.slave   dec_if
);

    localparam int NCW   = 64 / K;
    localparam int NSTEP = NCW / LANES;
    localparam int IDXW  = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    generate
        if (K != 4) begin : g_bad_k
            $error("matrix_decode_secded: only K=4 is supported");
        end
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
            $error("matrix_decode_secded: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    dec_state_e        state_q;
    logic [127:0]      cap_q;
    logic [IDXW-1:0]   idx_q;
    logic [63:0]       data_w_q;
    logic [4:0]        cnt_w_q;
    logic [15:0]       mask_w_q;
    logic              busy_q;
    logic              valid_q;
    logic [63:0]       data_out_q;
    logic [4:0]        corr_q;
    logic [15:0]       mask_q;
    logic              err_q;

    logic [LANES*4-1:0] lane_data;
    logic [LANES-1:0]   lane_corr;
    logic [LANES-1:0]   lane_unc;
    dec_status_e        lane_st [LANES];
    logic [4:0]         corr_sum;
    logic [63:0]        data_w_d;
    logic [4:0]         cnt_w_d;
    logic [15:0]        mask_w_d;
    logic               last_step;

    // The capture register shifts down each step, so lane gi always reads a fixed slot
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            secded_cw_dec u_dec (
                .cw_i     (cap_q[gi*8 +: 8]),
                .data_o   (lane_data[gi*4 +: 4]),
                .status_o (lane_st[gi])
            );
            assign lane_corr[gi] = (lane_st[gi] == ST_CORR);
            assign lane_unc[gi]  = (lane_st[gi] == ST_UNCORR);
        end
    endgenerate

    always_comb begin
        corr_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            corr_sum = corr_sum + 5'(lane_corr[l]);
        end
    end

    assign cnt_w_d   = cnt_w_q + corr_sum;
    assign last_step = (idx_q == IDXW'(NSTEP - 1));

    // Results enter at the top and slide down, landing codeword j at nibble j
    generate
        if (LANES == 16) begin : g_full
            assign data_w_d = lane_data;
            assign mask_w_d = lane_unc;
        end else begin : g_part
            assign data_w_d = {lane_data, data_w_q[63:LANES*4]};
            assign mask_w_d = {lane_unc, mask_w_q[15:LANES]};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cap_q      <= '0;
            idx_q      <= '0;
            data_w_q   <= '0;
            cnt_w_q    <= '0;
            mask_w_q   <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            data_out_q <= '0;
            corr_q     <= '0;
            mask_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    valid_q <= 1'b0;
                    if (dec_if.start) begin
                        cap_q    <= dec_if.Encoded_MEM_in;
                        data_w_q <= '0;
                        cnt_w_q  <= '0;
                        mask_w_q <= '0;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    cap_q    <= cap_q >> (LANES * 8);
                    data_w_q <= data_w_d;
                    cnt_w_q  <= cnt_w_d;
                    mask_w_q <= mask_w_d;
                    idx_q    <= idx_q + IDXW'(1);
                    if (last_step) begin
                        data_out_q <= data_w_d;
                        corr_q     <= cnt_w_d;
                        mask_q     <= mask_w_d;
                        err_q      <= |mask_w_d;
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_DONE;
                    end
                end
                S_DONE: begin
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dec_if.busy        = busy_q;
    assign dec_if.valid_out   = valid_q;
    assign dec_if.data_out    = data_out_q;
    assign dec_if.corr_count  = corr_q;
    assign dec_if.uncorr_mask = mask_q;
    assign dec_if.err_uncorr  = err_q;

endmodule

// File: doc/matrix_decode_secded.md
Name: matrix_decode_secded

Overview:
- SEC-DED decoder, the receive-side counterpart of the team's 64-bit nibble encoder.
- Takes the 128-bit flat encoded memory (16 codewords x 8 bits) and decodes LANES codewords per cycle under a small FSM.
- Corrects single-bit errors and flags double-bit errors per codeword.
- Returns the 64-bit data word with a one-cycle valid pulse, plus error status.

Parameters:
- K, 4: data bits per codeword. Only 4 is supported; any other value is an elaboration error.
- LANES, 1: codewords decoded per cycle. Legal values are 1, 2, 4, 8, 16.
- NCW (localparam), 64/K = 16: number of codewords.
- NSTEP (localparam), NCW/LANES: decode cycles per word.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle request; accepted only in IDLE.
- Encoded_MEM_in  in  128  codeword j at [j*8 +: 8].
- busy  out  1  high in DECODE.
- valid_out  out  1  one-cycle pulse, result valid.
- data_out  out  64  decoded word; codeword j maps to [j*4 +: 4].
- corr_count  out  5  codewords corrected (0..16).
- uncorr_mask  out  16  bit j set = codeword j uncorrectable.
- err_uncorr  out  1  OR of uncorr_mask.

Behaviour:
- Code (systematic [8,4,4]):
  - Generator rows G0=E1, G1=D2, G2=B4, G3=78 (hex).
  - cw[3:0] = d[3:0].
  - cw[4] = d1^d2^d3; cw[5] = d0^d2^d3; cw[6] = d0^d1^d3; cw[7] = d0^d1^d2.
- Syndrome: s[3:0] = cw[7:4] ^ parity(cw[3:0]).
  - s=0: no error; data = cw[3:0].
  - weight(s)=1: parity-bit error; data = cw[3:0]; counts as corrected.
  - s=E/D/B/7: data bit 0/1/2/3 in error; flip that bit; counts as corrected.
  - weight 2 or s=F: uncorrectable; data = cw[3:0] passed raw; set uncorr_mask[j]; not counted as corrected.
- Reset (reset=0, async): state IDLE, busy=0, valid_out=0, data_out=0, corr_count=0, uncorr_mask=0, err_uncorr=0. Internal capture/working registers cleared.
- FSM:
  - IDLE: on start=1 at edge T0, capture Encoded_MEM_in, clear working data/count/mask, idx=0, go to DECODE, busy=1.
  - DECODE: each edge decodes codewords idx*LANES .. idx*LANES+LANES-1 into working registers, then idx++. At edge TNSTEP (last step), copy working results to data_out/corr_count/uncorr_mask/err_uncorr, set valid_out=1, go to DONE, busy=0.
  - DONE: next edge clears valid_out and returns to IDLE. start is ignored in DONE.
- Latency: valid_out is high in the cycle after edge T(NSTEP). That is 16 cycles after the start edge for LANES=1, 1 cycle for LANES=16.
- Outputs data_out/corr_count/uncorr_mask/err_uncorr hold their values until the next completion. They never show partial results.
- start while busy or in DONE: ignored, no queuing. Encoded_MEM_in changes after T0 have no effect.
- Reset asserted mid-decode: immediate return to reset values; the in-flight operation is discarded and valid_out is never produced.
- corr_count is 5 bits; the maximum of 16 cannot overflow.

Decomposition:
- Shared package matrix_code_pkg holds:
  - G0..G3 constants (shared with the encoder);
  - the syndrome-to-bit column constants E, D, B, 7;
  - function parity4(nibble) returning 4 parity bits;
  - typedef for the 2-bit decode status (OK, CORR, UNCORR).
- One sub-module, secded_cw_dec: combinational decode of a single 8-bit codeword into a 4-bit data nibble plus status. It is instantiated LANES times.
- The FSM, index counter, and result registers live in the top module.

Test Plan:
- Clean all-ones (LANES=1): Encoded_MEM_in all FF, start 1 cycle -> valid_out high exactly 16 cycles after the start edge, one cycle wide; data_out=FFFFFFFFFFFFFFFF, corr_count=0, uncorr_mask=0000.
- Single data-bit error: all FF except byte0=FE -> data_out=FFFFFFFFFFFFFFFF, corr_count=1, err_uncorr=0.
- Parity-bit error: all 00 except byte15=10 -> data_out=0000000000000000, corr_count=1, uncorr_mask=0000.
- Double error: all FF except byte5=FC -> data_out=FFFFFFFFFFCFFFFF, uncorr_mask=0020, err_uncorr=1, corr_count=0.
- Handshake: start re-pulsed during DECODE and in DONE -> ignored, exactly one valid_out pulse. Input changed after T0 -> result reflects the T0 value. Byte0=E1, rest 00 -> data_out=0000000000000001.
- Reset mid-decode: reset low at cycle 7 of a decode -> all outputs 0 immediately, no valid_out. After release, a new start decodes correctly. Repeat the clean test with LANES=4 -> valid_out 4 cycles after the start edge.
